// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives a combinational-read instruction
// memory and presents each word to decode through a registered valid/ready stage.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 8
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module imem_fetch_ctrl #(
  parameter int                    ADDR_WIDTH = `MEM_ADDR_WIDTH,
  parameter int                    WORD_WIDTH = `WORD_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WORD_WIDTH-1:0] HALT_INST  = WORD_WIDTH'(32'h0000_0073)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [WORD_WIDTH-1:0] imem_inst,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [WORD_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  halted,
  output logic [31:0]           fetch_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  load;

  // The output stage can take a new word when it is empty or being drained this cycle.
  assign load      = !inst_valid || inst_ready;
  assign imem_addr = pc;
  assign halted    = (state == HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inst_valid  <= 1'b0;
      inst        <= '0;
      inst_pc     <= '0;
      fetch_count <= '0;
    end else begin
      // A handshake counts even when a redirect squashes the stage in the same cycle.
      if (inst_valid && inst_ready && (fetch_count != 32'hFFFF_FFFF))
        fetch_count <= fetch_count + 32'd1;

      unique case (state)
        IDLE: begin
          if (redirect_valid)
            pc <= redirect_pc;
          if (start)
            state <= RUN;
        end

        RUN: begin
          if (redirect_valid) begin
            pc         <= redirect_pc;
            inst_valid <= 1'b0;
          end else if (load) begin
            inst       <= imem_inst;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            pc         <= pc + 1'b1;
            if (imem_inst == HALT_INST)
              state <= HALTED;
          end
        end

        HALTED: begin
          // The halt word itself is still delivered; pc stays pointing past it.
          if (redirect_valid) begin
            pc         <= redirect_pc;
            inst_valid <= 1'b0;
          end else if (inst_ready) begin
            inst_valid <= 1'b0;
          end
          if (start)
            state <= RUN;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural fetch model.
module tb_imem_fetch_ctrl;

  localparam int AW    = 8;
  localparam int WW    = 32;
  localparam int DEPTH = 1 << AW;
  localparam logic [WW-1:0] HALT = 32'h0000_0073;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] imem_addr;
  logic [WW-1:0] imem_inst;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [WW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          halted;
  logic [31:0]   fetch_count;

  logic [WW-1:0] mem [DEPTH];

  int checks = 0;
  int failures = 0;
  bit compare_en = 1'b0;

  // Behavioural model: mode 0 idle, 1 running, 2 halted.
  int          m_mode = 0;
  int          m_pc = 0;
  bit          m_valid = 1'b0;
  logic [WW-1:0] m_inst = '0;
  int          m_ipc = 0;
  longint      m_cnt = 0;

  imem_fetch_ctrl #(
    .ADDR_WIDTH(AW),
    .WORD_WIDTH(WW),
    .RESET_PC  ('0),
    .HALT_INST (HALT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_inst     (imem_inst),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_inst = mem[imem_addr];

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit s, input bit rv, input logic [AW-1:0] rp, input bit rdy);
    start          = s;
    redirect_valid = rv;
    redirect_pc    = rp;
    inst_ready     = rdy;
  endtask

  // Model steps on the same edge as the DUT, from the inputs it saw at that edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_pc = 0; m_valid = 1'b0; m_inst = '0; m_ipc = 0; m_cnt = 0;
    end else begin
      if (m_valid && inst_ready && m_cnt < 64'hFFFF_FFFF)
        m_cnt = m_cnt + 1;
      if (m_mode == 0) begin
        if (redirect_valid) m_pc = int'(redirect_pc);
        if (start) m_mode = 1;
      end else if (m_mode == 1) begin
        if (redirect_valid) begin
          m_pc = int'(redirect_pc);
          m_valid = 1'b0;
        end else if (!m_valid || inst_ready) begin
          m_inst  = mem[m_pc];
          m_ipc   = m_pc;
          m_valid = 1'b1;
          m_pc    = (m_pc + 1) % DEPTH;
          if (m_inst == HALT) m_mode = 2;
        end
      end else begin
        if (redirect_valid) begin
          m_pc = int'(redirect_pc);
          m_valid = 1'b0;
        end else if (inst_ready) begin
          m_valid = 1'b0;
        end
        if (start) m_mode = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (compare_en) begin
      checkOutput("m_imem_addr", imem_addr, m_pc);
      checkOutput("m_inst_valid", inst_valid, m_valid);
      checkOutput("m_halted", halted, m_mode == 2);
      checkOutput("m_fetch_count", fetch_count, m_cnt);
      if (m_valid) begin
        checkOutput("m_inst", inst, m_inst);
        checkOutput("m_inst_pc", inst_pc, m_ipc);
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000_0000 + i;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    compare_en = 1'b1;
    checkOutput("reset_valid", inst_valid, 0);
    checkOutput("reset_addr", imem_addr, 0);
    checkOutput("reset_count", fetch_count, 0);
    checkOutput("reset_halted", halted, 0);

    // Start latency and steady stream.
    applyStimulus(1, 0, '0, 1);
    tick();
    applyStimulus(0, 0, '0, 1);
    checkOutput("start_valid_t1", inst_valid, 0);
    tick();
    checkOutput("a0_valid", inst_valid, 1);
    checkOutput("a0_inst", inst, 32'hA000_0000);
    checkOutput("a0_pc", inst_pc, 0);
    tick();
    checkOutput("a1_inst", inst, 32'hA000_0001);
    checkOutput("a1_pc", inst_pc, 1);
    tick();
    checkOutput("a2_inst", inst, 32'hA000_0002);
    checkOutput("a2_pc", inst_pc, 2);
    tick();
    checkOutput("count3", fetch_count, 3);

    // Backpressure at pc 5.
    tick();
    tick();
    checkOutput("bp_pc5", inst_pc, 5);
    applyStimulus(0, 0, '0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("bp_hold_pc", inst_pc, 5);
      checkOutput("bp_hold_inst", inst, 32'hA000_0005);
      checkOutput("bp_hold_addr", imem_addr, 6);
    end
    applyStimulus(0, 0, '0, 1);
    tick();
    checkOutput("bp_release_pc", inst_pc, 6);

    // Redirect while stalled.
    applyStimulus(0, 0, '0, 0);
    tick();
    applyStimulus(0, 1, 8'h20, 0);
    tick();
    checkOutput("redir_valid", inst_valid, 0);
    checkOutput("redir_addr", imem_addr, 8'h20);
    applyStimulus(0, 0, '0, 1);
    tick();
    checkOutput("redir_pc", inst_pc, 8'h20);
    checkOutput("redir_inst", inst, 32'hA000_0020);

    // Halt instruction at pc 3.
    mem[3] = HALT;
    applyStimulus(0, 1, '0, 1);
    tick();
    applyStimulus(0, 0, '0, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("halt_seq_pc", inst_pc, k);
    end
    checkOutput("halt_flag", halted, 1);
    checkOutput("halt_inst", inst, HALT);
    tick();
    checkOutput("halt_drained", inst_valid, 0);
    checkOutput("halt_addr", imem_addr, 4);
    tick();
    checkOutput("halt_no_pc4", inst_valid, 0);
    applyStimulus(1, 1, '0, 1);
    tick();
    applyStimulus(0, 0, '0, 1);
    checkOutput("resume_halted", halted, 0);
    tick();
    checkOutput("resume_pc0", inst_pc, 0);
    checkOutput("resume_valid", inst_valid, 1);
    mem[3] = 32'hA000_0003;

    // Wrap from all-ones to zero.
    applyStimulus(0, 1, 8'hFF, 1);
    tick();
    applyStimulus(0, 0, '0, 1);
    tick();
    checkOutput("wrap_ff", inst_pc, 8'hFF);
    tick();
    checkOutput("wrap_00", inst_pc, 0);

    // Asynchronous reset mid-stream.
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_valid", inst_valid, 0);
    checkOutput("arst_inst", inst, 0);
    checkOutput("arst_pc", inst_pc, 0);
    checkOutput("arst_addr", imem_addr, 0);
    checkOutput("arst_count", fetch_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("arst_idle", inst_valid, 0);
    end

    // Randomized traffic, compared against the model every cycle.
    for (int i = 0; i < DEPTH; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
    for (int c = 0; c < 2000; c++) begin
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                    AW'($urandom), $urandom_range(0, 9) < 7);
      if (c % 700 == 350) begin
        #2 rst = 1'b1;
        #3 rst = 1'b0;
      end
      tick();
    end

    compare_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
